// File: rtl/demultiplexer_1_to_n_registered_if.sv
// Producer/consumer bundle for demultiplexer_1_to_n_registered.
// The slave modport is the demultiplexer side and the master modport is the producer/consumer side.
interface demultiplexer_1_to_n_registered_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          select_lines;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic                      bad_select;

  modport master (
    output in_data, select_lines, in_valid, out_ready,
    input  in_ready, out_data, out_valid, bad_select
  );

  modport slave (
    input  in_data, select_lines, in_valid, out_ready,
    output in_ready, out_data, out_valid, bad_select
  );
endinterface

// File: rtl/demultiplexer_1_to_n_registered.sv
// Registered 1-to-N demultiplexer with a one-entry holding register and valid/ready handshake per channel.
// Optional build macro DEMUX_IDLE_ZERO_EN: an idle channel's data slice reads zero.
module demultiplexer_1_to_n_registered #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic clk,
  input  logic reset,
  demultiplexer_1_to_n_registered_if.slave bus
);
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic                      bad_q, bad_d;

  logic                      sel_ok_s;
  logic                      in_ready_s;
  logic                      accept_s;
  logic [CHANNELS-1:0]       pop_s;
  logic [(2**SEL_W)-1:0]     blocked_s;

  // Input acceptance: only the addressed channel can stall the producer.
  always_comb begin
    blocked_s                 = {(2**SEL_W){1'b0}};
    blocked_s[CHANNELS-1:0]   = valid_q & ~bus.out_ready;
    sel_ok_s                  = ({1'b0, bus.select_lines} < CH_LIMIT);
    if (sel_ok_s) begin
      in_ready_s = ~blocked_s[bus.select_lines];
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s = bus.in_valid & in_ready_s;
    pop_s    = valid_q & bus.out_ready;
  end

  // Next-state for channel holding registers and the sticky error flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    bad_d   = bad_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (accept_s && sel_ok_s && (bus.select_lines == SEL_W'(k))) begin
        // A same-cycle pop and load keeps the channel full at full throughput.
        valid_d[k]              = 1'b1;
        data_d[k*WIDTH +: WIDTH] = bus.in_data;
      end else if (pop_s[k]) begin
        valid_d[k] = 1'b0;
`ifdef DEMUX_IDLE_ZERO_EN
        data_d[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
`else
        data_d[k*WIDTH +: WIDTH] = data_q[k*WIDTH +: WIDTH];
`endif
      end else begin
        valid_d[k] = valid_q[k];
      end
    end
    if (accept_s && !sel_ok_s) begin
      bad_d = 1'b1;
    end else begin
      bad_d = bad_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= {(CHANNELS*WIDTH){1'b0}};
      valid_q <= {CHANNELS{1'b0}};
      bad_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.bad_select = bad_q;
endmodule

// File: tb/tb_demultiplexer_1_to_n_registered.sv
// Bench for demultiplexer_1_to_n_registered: a 4-channel and a 3-channel instance share stimulus,
// both checked against a per-channel behavioural model.
module tb_demultiplexer_1_to_n_registered;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  demultiplexer_1_to_n_registered_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) bus4 ();
  demultiplexer_1_to_n_registered_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) bus3 ();

  demultiplexer_1_to_n_registered #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );
  demultiplexer_1_to_n_registered #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  int total = 0;
  int bad   = 0;

  logic       mv [2][4];
  logic [7:0] md [2][4];
  logic       mb [2];
  int         nch [2] = '{4, 3};
  logic       last_rdy [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_data(input int m, input int k);
    if (m == 0) return bus4.out_data[k*8 +: 8];
    else return bus3.out_data[k*8 +: 8];
  endfunction

  function automatic logic [3:0] get_valid(input int m);
    if (m == 0) return bus4.out_valid;
    else return {1'b0, bus3.out_valid};
  endfunction

  function automatic logic get_bad(input int m);
    if (m == 0) return bus4.bad_select;
    else return bus3.bad_select;
  endfunction

  function automatic logic get_ready(input int m);
    if (m == 0) return bus4.in_ready;
    else return bus3.in_ready;
  endfunction

  function automatic logic exp_ready(input int m, input logic [1:0] s, input logic [3:0] r);
    if (int'(s) < nch[m]) return (!mv[m][s]) || r[s];
    else return 1'b1;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mb[m] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = 8'h00;
      end
    end
  endtask

  task automatic model_update(input int m, input logic [7:0] d, input logic [1:0] s,
                              input logic v, input logic [3:0] r, input logic rdy);
    for (int k = 0; k < nch[m]; k++) begin
      if (v && rdy && int'(s) == k) begin
        mv[m][k] = 1'b1;
        md[m][k] = d;
      end else if (mv[m][k] && r[k]) begin
        mv[m][k] = 1'b0;
`ifdef DEMUX_IDLE_ZERO_EN
        md[m][k] = 8'h00;
`endif
      end
    end
    if (v && int'(s) >= nch[m]) mb[m] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int m = 0; m < 2; m++) begin
      ev = 4'b0000;
      for (int k = 0; k < nch[m]; k++) begin
        ev[k] = mv[m][k];
        chk($sformatf("%s/dut%0d.data%0d", tag, nch[m], k), 32'(get_data(m, k)), 32'(md[m][k]));
      end
      chk($sformatf("%s/dut%0d.valid", tag, nch[m]), 32'(get_valid(m)), 32'(ev));
      chk($sformatf("%s/dut%0d.bad", tag, nch[m]), 32'(get_bad(m)), 32'(mb[m]));
    end
  endtask

  // One cycle: drive, check combinational ready, clock, check registered outputs.
  task automatic step(input string tag, input logic [7:0] d, input logic [1:0] s,
                      input logic v, input logic [3:0] r);
    logic er;
    bus4.in_data = d; bus4.select_lines = s; bus4.in_valid = v; bus4.out_ready = r;
    bus3.in_data = d; bus3.select_lines = s; bus3.in_valid = v; bus3.out_ready = r[2:0];
    #1;
    for (int m = 0; m < 2; m++) begin
      er = exp_ready(m, s, r);
      last_rdy[m] = get_ready(m);
      chk($sformatf("%s/dut%0d.in_ready", tag, nch[m]), 32'(last_rdy[m]), 32'(er));
      model_update(m, d, s, v, r, er);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b1;
    step_idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // Single word to channel 2, then it drains.
    step("tp1", 8'hA5, 2'd2, 1'b1, 4'b1111);
    chk("tp1_slice2", 32'(bus4.out_data[23:16]), 32'h0000_00A5);
    chk("tp1_valid", 32'(bus4.out_valid), 32'h0000_0004);
    step("tp1_drain", 8'h00, 2'd0, 1'b0, 4'b1111);
    chk("tp1_drained", 32'(bus4.out_valid), 32'h0000_0000);

    // Backpressure on channel 1.
    step("tp2_a", 8'h11, 2'd1, 1'b1, 4'b1101);
    step("tp2_b", 8'h22, 2'd1, 1'b1, 4'b1101);
    chk("tp2_stalled", 32'(last_rdy[0]), 32'h0000_0000);
    step("tp2_c", 8'h22, 2'd1, 1'b1, 4'b1111);
    chk("tp2_swap", 32'(bus4.out_data[15:8]), 32'h0000_0022);
    chk("tp2_keep", 32'(bus4.out_valid[1]), 32'h0000_0001);

    // Stalled channel 0 must not block channel 3 (invalid select on the 3-channel copy).
    step("tp3_a", 8'h44, 2'd0, 1'b1, 4'b1110);
    step("tp3_b", 8'h33, 2'd3, 1'b1, 4'b1110);
    chk("tp3_ready", 32'(last_rdy[0]), 32'h0000_0001);
    chk("tp3_ch3", 32'(bus4.out_data[31:24]), 32'h0000_0033);
    chk("tp3_ch0", 32'(bus4.out_data[7:0]), 32'h0000_0044);
    chk("tp5_badsel", 32'(bus3.bad_select), 32'h0000_0001);
    chk("tp5_ready3", 32'(last_rdy[1]), 32'h0000_0001);

    // Back-to-back round robin.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("tp4_%0d", i), 8'(8'h80 + i), 2'(i), 1'b1, 4'b1111);
      chk($sformatf("tp4_rdy%0d", i), 32'(last_rdy[0]), 32'h0000_0001);
    end

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), 8'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom), 4'($urandom));
    end

    // Fill channels, then reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("fill%0d", i), 8'(8'hC0 + i), 2'(i), 1'b1, 4'b0000);
    end
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check_outputs("midreset");
    chk("midreset_ready", 32'(bus4.in_ready), 32'(exp_ready(0, bus4.select_lines, bus4.out_ready)));
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 8'h5A, 2'd1, 1'b1, 4'b0000);
    step("post_reset2", 8'h00, 2'd0, 1'b0, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic step_idle_inputs();
    bus4.in_data = 8'h00; bus4.select_lines = 2'd0; bus4.in_valid = 1'b0; bus4.out_ready = 4'b0000;
    bus3.in_data = 8'h00; bus3.select_lines = 2'd0; bus3.in_valid = 1'b0; bus3.out_ready = 3'b000;
  endtask
endmodule
